maybe_byte_fifo: RTL and testbench



---
 rtl/maybe_pkg.sv | 20 ++
 rtl/maybe_fifo_mem.sv | 32 +++
 rtl/maybe_byte_fifo.sv | 110 +++++++++++
 tb/tb_maybe_byte_fifo.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/maybe_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | maybe_pkg                                                        |
// | Shared types and constants for the 8-bit Maybe stream.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package maybe_pkg;

  typedef logic [7:0] byte_t;

  typedef struct packed {
    logic  valid;
    byte_t data;
  } maybe_byte_t;

  localparam int          MAYBE_FIFO_DEPTH_DEFAULT = 8;
  localparam maybe_byte_t NOTHING_BYTE             = '{valid: 1'b0, data: 8'h00};

endpackage
`default_nettype wire

// File: rtl/maybe_fifo_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | maybe_fifo_mem                                                   |
// | DEPTH x 8 register array, synchronous write, async read.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module maybe_fifo_mem
  import maybe_pkg::*;
#(
  parameter int DEPTH  = MAYBE_FIFO_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  byte_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output byte_t             rdata
);

  byte_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/maybe_byte_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | maybe_byte_fifo                                                  |
// | Captures Just bytes of a Maybe stream into a FWFT FIFO with a    |
// | sticky overflow flag. MAYBE_FIFO_DROP_COUNT_EN adds drop_count.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module maybe_byte_fifo
  import maybe_pkg::*;
#(
  parameter  int DEPTH = MAYBE_FIFO_DEPTH_DEFAULT,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic [LVL_W-1:0] level,
  output logic             overflow
`ifdef MAYBE_FIFO_DROP_COUNT_EN
  ,
  output logic [7:0]       drop_count
`endif
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_overflow;

  maybe_byte_t w_in;
  maybe_byte_t w_head;
  byte_t       w_rdata;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;

  assign w_in    = '{valid: in_valid, data: in_data};
  assign w_full  = (r_level == FULL_LVL);
  assign w_empty = (r_level == '0);
  assign w_pop   = !w_empty && out_ready;
  // At full, a same-cycle pop frees the slot the incoming byte lands in.
  assign w_push  = w_in.valid && (!w_full || w_pop);
  assign w_drop  = w_in.valid && w_full && !w_pop;

  maybe_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_push && !rst),
    .waddr (r_wr_ptr),
    .wdata (w_in.data),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_W'(1);
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef MAYBE_FIFO_DROP_COUNT_EN
  logic [7:0] r_drop_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count <= 8'h00;
    end else if (w_drop && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'h01;
    end
  end

  assign drop_count = r_drop_count;
`endif

  always_comb begin
    w_head = NOTHING_BYTE;
    if (!w_empty) begin
      w_head = '{valid: 1'b1, data: w_rdata};
    end
  end

  assign out_valid = w_head.valid;
  assign out_data  = w_head.data;
  assign level     = r_level;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_maybe_byte_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_maybe_byte_fifo                                               |
// | Directed self-checking bench for maybe_byte_fifo (DEPTH = 8).    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_maybe_byte_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] level;
  logic       overflow;
`ifdef MAYBE_FIFO_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  maybe_byte_fifo #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow)
`ifdef MAYBE_FIFO_DROP_COUNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Records the byte handed over this cycle, then advances one edge.
  task automatic cycle();
    if (out_valid && out_ready) got_q.push_back(out_data);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check(tag, got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    // Reset then idle
    cycle(); cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("idle_valid", out_valid, 0);
      check("idle_level", level, 0);
      check("idle_ovf", overflow, 0);
      check("idle_data", out_data, 8'h00);
      cycle();
    end

    // Single pass
    in_valid = 1'b1; in_data = 8'hA5;
    cycle();
    in_valid = 1'b0;
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 8'hA5);
    check("single_level", level, 1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("single_drain_level", level, 0);
    check("single_drain_valid", out_valid, 0);
    got_q.delete();

    // Order and wrap: 20 Justs interleaved with Nothing cycles
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      exp_q.push_back(8'(i));
      cycle();
      in_valid = 1'b0; in_data = 8'hFF;
      cycle();
    end
    cycle(); cycle();
    compare_queues("wrap_order");
    check("wrap_ovf", overflow, 0);
    check("wrap_level", level, 0);

    // Full and drop
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = 8'h10 + 8'(i);
      cycle();
      if (i == 7) begin
        check("full_level", level, 8);
        check("full_ovf_before", overflow, 0);
      end
    end
    in_valid = 1'b0;
    check("drop_level", level, 8);
    check("drop_ovf", overflow, 1);
`ifdef MAYBE_FIFO_DROP_COUNT_EN
    check("drop_count", drop_count, 1);
`endif

    // Full with simultaneous push and pop
    in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("pushpop_level", level, 8);
    check("pushpop_ovf", overflow, 1);
`ifdef MAYBE_FIFO_DROP_COUNT_EN
    check("pushpop_drop_count", drop_count, 1);
`endif
    for (int i = 0; i < 10; i++) cycle();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
    exp_q.push_back(8'h99);
    compare_queues("drain_order");
    check("drain_level", level, 0);

    // Reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h50 + 8'(i);
      cycle();
    end
    check("mid_level", level, 5);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_level", level, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_data", out_data, 8'h00);
`ifdef MAYBE_FIFO_DROP_COUNT_EN
    check("rst_drop_count", drop_count, 0);
`endif
    cycle();
    check("rst_not_stored", level, 0);
    in_valid = 1'b1; in_data = 8'h33;
    cycle();
    in_valid = 1'b0;
    check("post_rst_data", out_data, 8'h33);
    check("post_rst_level", level, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
